// File: rtl/bcd_rtc_counter.sv
// bcd_rtc_counter: 24 h BCD time-of-day counter (00:00:00-23:59:59).
// It supports up/down counting, validated loads, a programmable reset time,
// a 12 h display view and a day-wrap pulse.
// Optional alarm comparator: define ALARM_EN to add the alarm ports and logic.
module bcd_rtc_counter #(
  parameter logic [7:0] RST_HH = 8'h12,
  parameter logic [7:0] RST_MM = 8'h00,
  parameter logic [7:0] RST_SS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_tick,
  input  logic       set_en,
  input  logic       set_load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       cnt_down,
  input  logic       mode_12h,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] disp_hh,
  output logic       pm,
  output logic       day_wrap,
  output logic       load_err
`ifdef ALARM_EN
  ,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  input  logic       alarm_clr,
  output logic       alarm_irq
`endif
);

  logic [7:0] r_hh, r_mm, r_ss;
  logic       r_day_wrap, r_load_err;
  logic [7:0] w_nxt_hh, w_nxt_mm, w_nxt_ss, w_disp_hh;
  logic       w_ss_end, w_mm_end, w_hh_end, w_wrap, w_tick, w_load_ok;

  // One BCD digit pair stepped up; wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)           return 8'h00;
    if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // One BCD digit pair stepped down; wraps to lim below 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00)         return lim;
    if (v[3:0] == 4'd0)     return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // A load is accepted only for a well-formed 24 h BCD time.
  assign w_load_ok = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                     (set_mm[7:4] <= 4'd9) && (set_mm[3:0] <= 4'd9) &&
                     (set_ss[7:4] <= 4'd9) && (set_ss[3:0] <= 4'd9) &&
                     (set_hh <= 8'h23) && (set_mm <= 8'h59) && (set_ss <= 8'h59);

  // Load wins over a coincident tick; set_en freezes counting only.
  assign w_tick = clk_1hz_tick && !set_en && !set_load;

  // Next time for a count step; carries/borrows ripple through each field end.
  always_comb begin
    w_ss_end = cnt_down ? (r_ss == 8'h00) : (r_ss == 8'h59);
    w_mm_end = cnt_down ? (r_mm == 8'h00) : (r_mm == 8'h59);
    w_hh_end = cnt_down ? (r_hh == 8'h00) : (r_hh == 8'h23);
    w_nxt_ss = cnt_down ? bcd_dec(r_ss, 8'h59) : bcd_inc(r_ss, 8'h59);
    w_nxt_mm = r_mm;
    w_nxt_hh = r_hh;
    if (w_ss_end)
      w_nxt_mm = cnt_down ? bcd_dec(r_mm, 8'h59) : bcd_inc(r_mm, 8'h59);
    if (w_ss_end && w_mm_end)
      w_nxt_hh = cnt_down ? bcd_dec(r_hh, 8'h23) : bcd_inc(r_hh, 8'h23);
    w_wrap = w_ss_end && w_mm_end && w_hh_end;
  end

  // Time registers plus the one-cycle day_wrap / load_err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hh       <= RST_HH;
      r_mm       <= RST_MM;
      r_ss       <= RST_SS;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
      if (set_load) begin
        if (w_load_ok) begin
          r_hh <= set_hh;
          r_mm <= set_mm;
          r_ss <= set_ss;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_tick) begin
        r_hh       <= w_nxt_hh;
        r_mm       <= w_nxt_mm;
        r_ss       <= w_nxt_ss;
        r_day_wrap <= w_wrap;
      end
    end
  end

  // 12 h view. For 13..23 subtract 12 in BCD: when the units digit is >= 2,
  // a plain 0x12 subtract never borrows; for 20/21 subtract 0x18 instead,
  // which is 0x12 plus the 6-step decimal-adjust for the units borrow.
  always_comb begin
    w_disp_hh = r_hh;
    if (mode_12h) begin
      if (r_hh == 8'h00)
        w_disp_hh = 8'h12;
      else if (r_hh > 8'h12)
        w_disp_hh = (r_hh[3:0] >= 4'd2) ? (r_hh - 8'h12) : (r_hh - 8'h18);
    end
  end

  assign hh       = r_hh;
  assign mm       = r_mm;
  assign ss       = r_ss;
  assign disp_hh  = w_disp_hh;
  assign pm       = (r_hh >= 8'h12);
  assign day_wrap = r_day_wrap;
  assign load_err = r_load_err;

`ifdef ALARM_EN
  logic r_alarm_irq;
  logic w_alarm_hit;

  // Only tick-driven updates landing on hh:mm:00 can fire the alarm.
  assign w_alarm_hit = w_tick && alarm_arm &&
                       ({w_nxt_hh, w_nxt_mm, w_nxt_ss} == {alarm_hh, alarm_mm, 8'h00});

  // Sticky alarm flag; a new hit beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_alarm_irq <= 1'b0;
    else if (w_alarm_hit) r_alarm_irq <= 1'b1;
    else if (alarm_clr)   r_alarm_irq <= 1'b0;
  end

  assign alarm_irq = r_alarm_irq;
`endif

endmodule

// File: tb/tb_bcd_rtc_counter.sv
// Bench for bcd_rtc_counter: directed cases with literal expectations, then
// randomized traffic checked every cycle against a seconds-of-day model.
module tb_bcd_rtc_counter;
  localparam int DAY   = 86400;
  localparam int RST_T = 12 * 3600;

  logic       clk = 1'b0, rst = 1'b0;
  logic       tick = 1'b0, set_en = 1'b0, set_load = 1'b0;
  logic       cnt_down = 1'b0, mode_12h = 1'b0;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
  logic [7:0] hh, mm, ss, disp_hh;
  logic       pm, day_wrap, load_err;
`ifdef ALARM_EN
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic       alarm_arm = 1'b0, alarm_clr = 1'b0;
  logic       alarm_irq;
`endif

  int n_cmp = 0, n_bad = 0;
  bit run = 1'b0;

  bcd_rtc_counter dut (
    .clk(clk), .rst(rst), .clk_1hz_tick(tick), .set_en(set_en),
    .set_load(set_load), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .cnt_down(cnt_down), .mode_12h(mode_12h),
    .hh(hh), .mm(mm), .ss(ss), .disp_hh(disp_hh), .pm(pm),
    .day_wrap(day_wrap), .load_err(load_err)
`ifdef ALARM_EN
    , .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
    .alarm_clr(alarm_clr), .alarm_irq(alarm_irq)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int b2d(input logic [7:0] v);
    return 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] d2b(input int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  function automatic bit fld_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (b2d(v) <= lim);
  endfunction

  function automatic bit load_ok(input logic [7:0] h, m, s);
    return fld_ok(h, 23) && fld_ok(m, 59) && fld_ok(s, 59);
  endfunction

  function automatic int to_sec(input logic [7:0] h, m, s);
    return 3600 * b2d(h) + 60 * b2d(m) + b2d(s);
  endfunction

  function automatic int nxt(input int t, input logic down);
    return down ? (t + DAY - 1) % DAY : (t + 1) % DAY;
  endfunction

  function automatic logic [7:0] exp_disp(input int t, input logic m12);
    int h;
    h = t / 3600;
    if (!m12) return d2b(h);
    return d2b((h % 12 == 0) ? 12 : h % 12);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: time as seconds of day ----------------
  int m_t = RST_T;
  bit m_wrap = 1'b0, m_err = 1'b0, m_irq = 1'b0;
  wire m_cnt = tick && !set_en && !set_load;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= RST_T; m_wrap <= 1'b0; m_err <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_err  <= set_load && !load_ok(set_hh, set_mm, set_ss);
      m_wrap <= m_cnt && (cnt_down ? (m_t == 0) : (m_t == DAY - 1));
      if (set_load) begin
        if (load_ok(set_hh, set_mm, set_ss)) m_t <= to_sec(set_hh, set_mm, set_ss);
      end else if (m_cnt) begin
        m_t <= nxt(m_t, cnt_down);
      end
`ifdef ALARM_EN
      if (m_cnt && alarm_arm && nxt(m_t, cnt_down) == to_sec(alarm_hh, alarm_mm, 8'h00))
        m_irq <= 1'b1;
      else if (alarm_clr)
        m_irq <= 1'b0;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (run) begin
      chk("hh", hh, d2b(m_t / 3600));
      chk("mm", mm, d2b((m_t / 60) % 60));
      chk("ss", ss, d2b(m_t % 60));
      chk("disp_hh", disp_hh, exp_disp(m_t, mode_12h));
      chk("pm", pm, m_t >= 12 * 3600);
      chk("day_wrap", day_wrap, m_wrap);
      chk("load_err", load_err, m_err);
`ifdef ALARM_EN
      chk("alarm_irq", alarm_irq, m_irq);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] h, m, s);
    set_hh = h; set_mm = m; set_ss = s; set_load = 1'b1;
    step();
    set_load = 1'b0;
  endtask

  task automatic chk_time(input string nm, input logic [7:0] h, m, s);
    chk(nm, {8'h00, hh, mm, ss}, {8'h00, h, m, s});
  endtask

  logic [7:0] sw_h [7] = '{8'h00, 8'h01, 8'h12, 8'h13, 8'h19, 8'h20, 8'h23};
  logic [7:0] sw_d [7] = '{8'h12, 8'h01, 8'h12, 8'h01, 8'h07, 8'h08, 8'h11};
  logic       sw_p [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int t;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    // reset state
    chk_time("rst_time", 8'h12, 8'h00, 8'h00);
    chk("rst_disp", disp_hh, 8'h12);
    chk("rst_pm", pm, 1'b1);
    chk("rst_wrap", day_wrap, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("model_rst", m_t, 43200);

    // up wrap
    load(8'h23, 8'h59, 8'h58);
    tick = 1'b1;
    step();
    chk_time("up1", 8'h23, 8'h59, 8'h59);
    chk("up1_wrap", day_wrap, 1'b0);
    step();
    chk_time("up2", 8'h00, 8'h00, 8'h00);
    chk("up2_wrap", day_wrap, 1'b1);
    chk("model_up2", m_t, 0);
    tick = 1'b0;
    step();
    chk("up3_wrap", day_wrap, 1'b0);

    // down wrap and borrow
    load(8'h00, 8'h00, 8'h00);
    cnt_down = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    chk_time("dn1", 8'h23, 8'h59, 8'h59);
    chk("dn1_wrap", day_wrap, 1'b1);
    load(8'h10, 8'h00, 8'h00);
    chk("dn_load_wrap", day_wrap, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk_time("dn2", 8'h09, 8'h59, 8'h59);
    chk("dn2_wrap", day_wrap, 1'b0);
    cnt_down = 1'b0;

    // rejected loads
    load(8'h24, 8'h00, 8'h00);
    chk("err_hh", load_err, 1'b1);
    chk_time("err_hh_t", 8'h09, 8'h59, 8'h59);
    step();
    chk("err_clr", load_err, 1'b0);
    load(8'h00, 8'h00, 8'h5A);
    chk("err_ss", load_err, 1'b1);
    chk_time("err_ss_t", 8'h09, 8'h59, 8'h59);

    // load with coincident tick, then frozen counting
    tick = 1'b1;
    load(8'h01, 8'h02, 8'h03);
    tick = 1'b0;
    chk_time("ld_tick", 8'h01, 8'h02, 8'h03);
    set_en = 1'b1; tick = 1'b1;
    repeat (10) step();
    set_en = 1'b0; tick = 1'b0;
    chk_time("set_en", 8'h01, 8'h02, 8'h03);

    // 12 h display sweep
    mode_12h = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load(sw_h[i], 8'h00, 8'h00);
      chk("sweep_disp", disp_hh, sw_d[i]);
      chk("sweep_pm", pm, sw_p[i]);
    end
    mode_12h = 1'b0;

    // asynchronous reset mid-count
    load(8'h05, 8'h05, 8'h05);
    tick = 1'b1;
    repeat (3) step();
    #2 rst = 1'b1;
    #1 chk_time("async_rst", 8'h12, 8'h00, 8'h00);
    step();
    rst = 1'b0;
    step();
    tick = 1'b0;
    chk_time("resume", 8'h12, 8'h00, 8'h01);

`ifdef ALARM_EN
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b1;
    load(8'h07, 8'h29, 8'h59);
    chk("al_pre", alarm_irq, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk_time("al_t", 8'h07, 8'h30, 8'h00);
    chk("al_set", alarm_irq, 1'b1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("al_clr", alarm_irq, 1'b0);
    load(8'h07, 8'h30, 8'h00);
    chk("al_load", alarm_irq, 1'b0);
    load(8'h07, 8'h30, 8'h01);
    cnt_down = 1'b1; tick = 1'b1; alarm_clr = 1'b1;
    step();
    tick = 1'b0; cnt_down = 1'b0; alarm_clr = 1'b0;
    chk("al_down_win", alarm_irq, 1'b1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
`endif

    // randomized traffic
    repeat (3000) begin
      tick     = ($urandom % 2) == 0;
      set_en   = ($urandom % 8) == 0;
      set_load = ($urandom % 16) == 0;
      mode_12h = ($urandom % 2) == 0;
      if ($urandom % 8 == 0) cnt_down = ~cnt_down;
      if ($urandom % 4 == 0) begin
        set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom);
      end else begin
        case ($urandom % 3)
          0:       t = DAY - 1 - int'($urandom % 3);
          1:       t = int'($urandom % 3);
          default: t = int'($urandom_range(0, DAY - 1));
        endcase
        set_hh = d2b(t / 3600); set_mm = d2b((t / 60) % 60); set_ss = d2b(t % 60);
      end
`ifdef ALARM_EN
      alarm_arm = ($urandom % 4) != 0;
      alarm_clr = ($urandom % 16) == 0;
      if ($urandom % 16 == 0) begin alarm_hh = hh; alarm_mm = mm; end
`endif
      if ($urandom % 500 == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    set_load = 1'b0; tick = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
